// File: rtl/lcd_frame_scheduler.sv
`timescale 1ns/1ps
// LCD frame scheduler: owns the shared lcd_write {dc,byte} port after init, sending window commands then a pixel stream.
// Define LCD_SCHED_PATTERN_EN to add the internal 8-bar colour pattern source selected by pattern_sel.
module lcd_frame_scheduler #(
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 160
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic [8:0] init_data,
  input  logic       init_en,
  output logic       init_wr_done,
  input  logic       frame_req,
  output logic       frame_busy,
  output logic       frame_done,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic       pix_ready,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  input  logic       pattern_sel,
  output logic [8:0] lcd_data,
  output logic       lcd_en,
  input  logic       wr_done,
  output logic       underrun
);

  localparam logic [17:0] TOTAL  = 18'(WIDTH * HEIGHT);
  localparam logic [15:0] XS     = 16'(X0);
  localparam logic [15:0] YS     = 16'(Y0);
  localparam logic [15:0] X1     = 16'(X0 + WIDTH - 1);
  localparam logic [15:0] Y1     = 16'(Y0 + HEIGHT - 1);
  localparam logic [8:0]  X_LAST = 9'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);

  typedef enum logic [2:0] {WAIT_INIT, IDLE, CMD, PIX, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic        lcd_en_r, lcd_en_n;
  logic [8:0]  lcd_data_r, lcd_data_n;
  logic        frame_busy_r, frame_busy_n;
  logic [8:0]  pix_x_r, pix_x_n, pix_y_r, pix_y_n;
  logic [17:0] fetched, fetched_n, sent, sent_n;
  logic        wr_ack, slot_free, fetch_left, take, pat_active;
  logic [7:0]  pix_byte;

  function automatic logic [8:0] cmd_byte_at(logic [3:0] i);
    case (i)
      4'd0:    return {1'b0, 8'h2A};
      4'd1:    return {1'b1, XS[15:8]};
      4'd2:    return {1'b1, XS[7:0]};
      4'd3:    return {1'b1, X1[15:8]};
      4'd4:    return {1'b1, X1[7:0]};
      4'd5:    return {1'b0, 8'h2B};
      4'd6:    return {1'b1, YS[15:8]};
      4'd7:    return {1'b1, YS[7:0]};
      4'd8:    return {1'b1, Y1[15:8]};
      4'd9:    return {1'b1, Y1[7:0]};
      default: return {1'b0, 8'h2C};
    endcase
  endfunction

`ifdef LCD_SCHED_PATTERN_EN
  logic       pat_r, pat_n;
  logic [2:0] bar;
  logic [7:0] bar_colour;

  // First column of bar k is ceil(k*WIDTH/8), so bar = floor(pix_x*8/WIDTH) without a divider.
  function automatic logic [8:0] bar_start(int unsigned k);
    return 9'((k * WIDTH + 7) / 8);
  endfunction

  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++)
      if (pix_x_r >= bar_start(k)) bar = 3'(k);
  end

  always_comb begin
    case (bar)
      3'd0:    bar_colour = 8'h00;
      3'd1:    bar_colour = 8'hFF;
      3'd2:    bar_colour = 8'hE0;
      3'd3:    bar_colour = 8'h1C;
      3'd4:    bar_colour = 8'h03;
      3'd5:    bar_colour = 8'hFC;
      3'd6:    bar_colour = 8'h1F;
      default: bar_colour = 8'hE3;
    endcase
  end

  assign pat_active = pat_r;
  assign pix_byte   = pat_r ? bar_colour : pix_data;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_active = 1'b0;
  assign pix_byte   = pix_data;
`endif

  assign wr_ack     = wr_done & lcd_en_r;
  assign slot_free  = ~lcd_en_r | wr_done;
  assign fetch_left = fetched < TOTAL;
  assign pix_ready  = (state == PIX) & slot_free & fetch_left & ~pat_active;
  assign take       = (state == PIX) & slot_free & fetch_left & (pat_active | pix_valid);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    lcd_en_n     = lcd_en_r;
    lcd_data_n   = lcd_data_r;
    frame_busy_n = frame_busy_r;
    pix_x_n      = pix_x_r;
    pix_y_n      = pix_y_r;
    fetched_n    = fetched;
    sent_n       = sent;
`ifdef LCD_SCHED_PATTERN_EN
    pat_n        = pat_r;
`endif
    case (state)
      WAIT_INIT: if (init_done) state_n = IDLE;
      IDLE: begin
        if (frame_req) begin
          state_n      = CMD;
          idx_n        = '0;
          lcd_data_n   = cmd_byte_at(4'd0);
          lcd_en_n     = 1'b1;
          frame_busy_n = 1'b1;
`ifdef LCD_SCHED_PATTERN_EN
          pat_n        = pattern_sel;
`endif
        end
      end
      CMD: begin
        if (wr_ack) begin
          if (idx == 4'd10) begin
            state_n  = PIX;
            lcd_en_n = 1'b0;
          end else begin
            idx_n      = idx + 4'd1;
            lcd_data_n = cmd_byte_at(idx + 4'd1);
          end
        end
      end
      PIX: begin
        if (take) begin
          lcd_data_n = {1'b1, pix_byte};
          lcd_en_n   = 1'b1;
          fetched_n  = fetched + 18'd1;
          if (pix_x_r == X_LAST) begin
            pix_x_n = '0;
            pix_y_n = (pix_y_r == Y_LAST) ? '0 : pix_y_r + 9'd1;
          end else begin
            pix_x_n = pix_x_r + 9'd1;
          end
        end else if (wr_ack) begin
          lcd_en_n = 1'b0;
        end
        // The final pixel's ack can never coincide with a fetch, so lcd_en drops above.
        if (wr_ack) begin
          sent_n = sent + 18'd1;
          if (sent == TOTAL - 18'd1) state_n = DONE;
        end
      end
      DONE: begin
        state_n      = IDLE;
        lcd_en_n     = 1'b0;
        frame_busy_n = 1'b0;
        pix_x_n      = '0;
        pix_y_n      = '0;
        fetched_n    = '0;
        sent_n       = '0;
      end
      default: state_n = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_INIT;
      idx          <= '0;
      lcd_en_r     <= 1'b0;
      lcd_data_r   <= '0;
      frame_busy_r <= 1'b0;
      pix_x_r      <= '0;
      pix_y_r      <= '0;
      fetched      <= '0;
      sent         <= '0;
`ifdef LCD_SCHED_PATTERN_EN
      pat_r        <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      lcd_en_r     <= lcd_en_n;
      lcd_data_r   <= lcd_data_n;
      frame_busy_r <= frame_busy_n;
      pix_x_r      <= pix_x_n;
      pix_y_r      <= pix_y_n;
      fetched      <= fetched_n;
      sent         <= sent_n;
`ifdef LCD_SCHED_PATTERN_EN
      pat_r        <= pat_n;
`endif
    end
  end

  assign lcd_data     = (state == WAIT_INIT) ? init_data : lcd_data_r;
  assign lcd_en       = (state == WAIT_INIT) ? init_en : lcd_en_r;
  assign init_wr_done = (state == WAIT_INIT) & wr_done;
  assign frame_busy   = frame_busy_r;
  assign frame_done   = (state == DONE);
  assign pix_x        = pix_x_r;
  assign pix_y        = pix_y_r;
  assign underrun     = (state == PIX) & ~lcd_en_r;

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
Sits between the panel init sequencer, a pixel source and the shared `lcd_write` SPI byte serializer. Arbitrates the single `{dc,byte}` write port:
- Until `init_done`, the init sequencer owns the port.
- After that, each frame request runs one command sequence: CASET, RASET, RAMWR with window parameters.
- It then streams exactly WIDTH*HEIGHT RGB332 pixels from the pixel source in raster order, with a valid/ready handshake and underrun stalling.

Parameters:
- X0, 0: window start column.
- Y0, 0: window start row.
- WIDTH, 240: window width in pixels (1..511).
- HEIGHT, 160: window height in pixels (1..511).

Ports:
- `clk_25MHz` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `init_done` in 1: init sequence complete (level, stays high).
- `init_data` in 9: init sequencer `{dc,byte}`.
- `init_en` in 1: init sequencer write enable.
- `init_wr_done` out 1: `wr_done` forwarded to init sequencer.
- `frame_req` in 1: level; start a frame when idle.
- `frame_busy` out 1: high from frame start until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last pixel byte completes.
- `pix_x` out 9: window-relative column of the pixel being requested.
- `pix_y` out 9: window-relative row of the pixel being requested.
- `pix_ready` out 1: scheduler can accept `pix_data` this cycle.
- `pix_valid` in 1: source presents `pix_data`.
- `pix_data` in 8: RGB332 pixel.
- `pattern_sel` in 1: internal colour-bar source select (see Optional Feature).
- `lcd_data` out 9: `{dc,byte}` to `lcd_write` `data`.
- `lcd_en` out 1: to `lcd_write` `en_write`.
- `wr_done` in 1: one-cycle pulse from `lcd_write` when the presented byte has been sent.
- `underrun` out 1: high while in PIX with `lcd_en` low (stall indicator).

Behaviour:
- **Write-port contract**
  - `lcd_en`=1 means `lcd_data` holds a pending byte, held stable until `wr_done`.
  - On the `wr_done` cycle the scheduler either loads the next byte (`lcd_en` stays 1) or drops `lcd_en` at that edge.
  - `wr_done` while `lcd_en`=0 is ignored.
- **Reset values:** state=WAIT_INIT, `lcd_en_r`=0, `lcd_data_r`=0, `frame_busy`=0, `frame_done`=0, `pix_x`=0, `pix_y`=0, counters=0.
- **WAIT_INIT**
  - `lcd_data`=`init_data`, `lcd_en`=`init_en`, `init_wr_done`=`wr_done` (combinational pass-through).
  - `init_done`=1 moves to IDLE at the next edge.
  - In every other state `init_wr_done`=0 and `lcd_data`/`lcd_en` come from registers.
- **IDLE**
  - If `frame_req`=1: go to CMD with idx=0, load byte 0, `lcd_en`=1, `frame_busy`=1.
  - If `frame_req` stays high, back-to-back frames run with exactly one IDLE cycle between them.
- **CMD (idx 0..10), byte order**
  - idx 0: {0,0x2A}.
  - idx 1-4: {1,X0[15:8]}, {1,X0[7:0]}, {1,X1[15:8]}, {1,X1[7:0]}, where X1=X0+WIDTH-1 (16-bit).
  - idx 5: {0,0x2B}.
  - idx 6-9: Y0 and Y1 bytes in the same order, Y1=Y0+HEIGHT-1.
  - idx 10: {0,0x2C}.
  - Each `wr_done` advances idx and loads the next byte.
  - `wr_done` at idx 10 goes to PIX with `lcd_en`=0.
- **PIX**
  - `pix_ready` = (state==PIX) & (`lcd_en`==0 | `wr_done`) & (fetched < WIDTH*HEIGHT). Combinational in `wr_done`.
  - On `pix_valid` & `pix_ready`: `lcd_data`<={1,`pix_data`}, `lcd_en`<=1, fetched++, advance `pix_x`/`pix_y`.
  - `pix_x`/`pix_y` advance raster order: `pix_x` wraps WIDTH-1 to 0 and increments `pix_y`; `pix_y` wraps HEIGHT-1 to 0.
  - On `wr_done` without a handshake: `lcd_en`<=0 (underrun stall; no data corruption, no timeout).
  - sent++ on each `wr_done`.
  - `wr_done` with sent==WIDTH*HEIGHT-1 goes to DONE.
  - Counters are 18 bits; fetch never exceeds WIDTH*HEIGHT.
- **DONE**
  - `frame_done`=1 for one cycle, `frame_busy`<=0, `pix_x`/`pix_y`/counters cleared, go to IDLE.
- **Edge cases**
  - `frame_req` while busy is ignored; it is not queued.
  - `init_done` falling after WAIT_INIT is ignored.
  - Reset mid-frame aborts immediately to the reset state with `lcd_en`=0.

Optional Feature:
- Macro `LCD_SCHED_PATTERN_EN`.
- **Defined, `pattern_sel`=1 sampled at frame start (held for the whole frame):**
  - PIX ignores `pix_valid` and `pix_ready`=0.
  - Pixel byte is generated internally without stalls as 8 vertical bars, bar=(`pix_x`*8)/WIDTH, implemented by comparing against constant thresholds.
  - Bar colours in order: 00,FF,E0,1C,03,FC,1F,E3.
- **Undefined:** `pattern_sel` is ignored and no pattern logic is synthesized.

Test Plan:
- **Init pass-through** (WIDTH=4, HEIGHT=2, X0=2, Y0=1): with `init_done`=0, drive `init_data`=0x011, `init_en`=1, pulse `wr_done` -> `lcd_data`=0x011, `lcd_en`=1, `init_wr_done` pulses.
- **Command bytes:** `init_done`=1, `frame_req` pulse, `wr_done` every 4 cycles -> bytes 0x02A,0x100,0x102,0x100,0x105,0x02B,0x100,0x101,0x100,0x102,0x02C.
- **Pixel stream:** source always valid, `pix_data`=`pix_x`+16*`pix_y` -> 8 bytes 0x100..0x103,0x110..0x113; `frame_done` pulses once, `frame_busy` falls.
- **Underrun:** `pix_valid` low 10 cycles after pixel 3 -> `lcd_en`=0 and `underrun`=1 for that window, no extra `wr_done` consumed, pixel 4 sent intact after resume.
- **Back-to-back and aborts:** `frame_req` held high -> second frame starts one cycle after `frame_done`. `frame_req` mid-frame -> no effect. `rst_n` low mid-PIX -> outputs return to reset values asynchronously.
- **Colour bars (with `LCD_SCHED_PATTERN_EN`, WIDTH=16, HEIGHT=1, `pattern_sel`=1):** pixels are 00,00,FF,FF,E0,E0,...,E3,E3 and `pix_ready` stays 0.
